dmac_desc_queue: RTL and testbench

Per-core DMA descriptor front end for the cluster DMA. It accepts transfer programming from the NB_CORES core control ports (XBAR_TCDM_BUS-style req/gnt/r_valid), holds one staged descriptor per core, and allocates a transfer ID (TID). It arbitrates launched descriptors round-robin onto a single valid/ready descriptor stream towards the DMA backend and AXI crossbar. On backend completion it retires the TID and raises term_event/term_irq to the issuing core.

---
 rtl/dmac_desc_pkg.sv | 35 +++
 rtl/dmac_tid_alloc.sv | 84 ++++++++
 rtl/dmac_desc_queue.sv | 198 +++++++++++++++++++
 tb/tb_dmac_desc_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmac_desc_pkg.sv
// Shared register map, CONF bit positions and descriptor record for the DMA descriptor front end.
// Pure declarations: no latency, no flow control.
package dmac_desc_pkg;

  localparam int DESC_ADDR_W  = 64;
  localparam int DESC_LEN_W   = 32;
  localparam int DESC_TID_W   = 4;
  localparam int NUM_CFG_REGS = 6;

  localparam logic [2:0] OFF_SRC_LO = 3'd0;
  localparam logic [2:0] OFF_SRC_HI = 3'd1;
  localparam logic [2:0] OFF_DST_LO = 3'd2;
  localparam logic [2:0] OFF_DST_HI = 3'd3;
  localparam logic [2:0] OFF_LEN    = 3'd4;
  localparam logic [2:0] OFF_CONF   = 3'd5;
  localparam logic [2:0] OFF_LAUNCH = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  localparam int CONF_DECOUPLE = 0;
  localparam int CONF_IRQ_EN   = 1;
  localparam int CONF_EVENT_EN = 2;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] src;
    logic [DESC_ADDR_W-1:0] dst;
    logic [DESC_LEN_W-1:0]  len;
    logic [DESC_TID_W-1:0]  tid;
    logic                   decouple;
  } desc_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/dmac_tid_alloc.sv
// In-order TID allocator with outstanding bitmap and per-TID {owner, irq_en, event_en} table.
// Alloc/retire land on the next edge; term pulses are registered one cycle after retire, no backpressure.
module dmac_tid_alloc #(
  parameter int NB_CORES  = 4,
  parameter int TID_WIDTH = 4,
  parameter int CORE_W    = (NB_CORES > 1) ? $clog2(NB_CORES) : 1,
  parameter int NTID      = 2**TID_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_i,
  input  logic [CORE_W-1:0]    alloc_core_i,
  input  logic                 alloc_irq_en_i,
  input  logic                 alloc_event_en_i,
  output logic [TID_WIDTH-1:0] next_tid_o,
  output logic                 next_free_o,
  input  logic                 retire_i,
  input  logic [TID_WIDTH-1:0] retire_tid_i,
  output logic [NTID-1:0]      bitmap_o,
  output logic [NB_CORES-1:0]  term_event_o,
  output logic [NB_CORES-1:0]  term_irq_o
);

  logic [TID_WIDTH-1:0] next_tid_q, next_tid_d;
  logic [NTID-1:0]      bitmap_q, bitmap_d;
  logic [NTID-1:0]      irq_en_q, irq_en_d;
  logic [NTID-1:0]      event_en_q, event_en_d;
  logic [CORE_W-1:0]    owner_q [NTID];
  logic [CORE_W-1:0]    owner_d [NTID];
  logic [NB_CORES-1:0]  term_event_q, term_event_d;
  logic [NB_CORES-1:0]  term_irq_q, term_irq_d;
  logic                 retire_hit;

  assign next_free_o  = !bitmap_q[next_tid_q];
  assign retire_hit   = retire_i && bitmap_q[retire_tid_i];
  assign next_tid_o   = next_tid_q;
  assign bitmap_o     = bitmap_q;
  assign term_event_o = term_event_q;
  assign term_irq_o   = term_irq_q;

  always_comb begin
    next_tid_d   = next_tid_q;
    bitmap_d     = bitmap_q;
    irq_en_d     = irq_en_q;
    event_en_d   = event_en_q;
    owner_d      = owner_q;
    term_event_d = '0;
    term_irq_d   = '0;
    // A retiring TID is set and an allocated TID is clear, so both can proceed in one cycle.
    if (retire_hit) begin
      bitmap_d[retire_tid_i]                = 1'b0;
      term_event_d[owner_q[retire_tid_i]]   = event_en_q[retire_tid_i];
      term_irq_d[owner_q[retire_tid_i]]     = irq_en_q[retire_tid_i];
    end
    if (alloc_i && next_free_o) begin
      bitmap_d[next_tid_q]   = 1'b1;
      owner_d[next_tid_q]    = alloc_core_i;
      irq_en_d[next_tid_q]   = alloc_irq_en_i;
      event_en_d[next_tid_q] = alloc_event_en_i;
      next_tid_d             = next_tid_q + TID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_tid_q   <= '0;
      bitmap_q     <= '0;
      irq_en_q     <= '0;
      event_en_q   <= '0;
      term_event_q <= '0;
      term_irq_q   <= '0;
      for (int t = 0; t < NTID; t++) owner_q[t] <= '0;
    end else begin
      next_tid_q   <= next_tid_d;
      bitmap_q     <= bitmap_d;
      irq_en_q     <= irq_en_d;
      event_en_q   <= event_en_d;
      term_event_q <= term_event_d;
      term_irq_q   <= term_irq_d;
      owner_q      <= owner_d;
    end
  end

endmodule

// File: rtl/dmac_desc_queue.sv
// Per-core DMA descriptor front end: control registers, one staged descriptor per core, RR launch and output arbitration.
// Control response 1 cycle after gnt; LAUNCH stalls (gnt=0) on full slot or busy next TID; desc_* held while valid && !ready.
module dmac_desc_queue
  import dmac_desc_pkg::*;
#(
  parameter int NB_CORES       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int DMA_ADDR_WIDTH = DESC_ADDR_W,
  parameter int LEN_WIDTH      = DESC_LEN_W,
  parameter int TID_WIDTH      = DESC_TID_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NB_CORES-1:0]                  ctrl_req_i,
  input  logic [NB_CORES-1:0]                  ctrl_wen_i,
  input  logic [NB_CORES-1:0][ADDR_WIDTH-1:0]  ctrl_add_i,
  input  logic [NB_CORES-1:0][DATA_WIDTH-1:0]  ctrl_wdata_i,
  input  logic [NB_CORES-1:0][BE_WIDTH-1:0]    ctrl_be_i,
  output logic [NB_CORES-1:0]                  ctrl_gnt_o,
  output logic [NB_CORES-1:0]                  ctrl_r_valid_o,
  output logic [NB_CORES-1:0][DATA_WIDTH-1:0]  ctrl_r_rdata_o,
  output logic                                 desc_valid_o,
  input  logic                                 desc_ready_i,
  output logic [DMA_ADDR_WIDTH-1:0]            desc_src_o,
  output logic [DMA_ADDR_WIDTH-1:0]            desc_dst_o,
  output logic [LEN_WIDTH-1:0]                 desc_len_o,
  output logic [TID_WIDTH-1:0]                 desc_tid_o,
  output logic                                 desc_decouple_o,
  input  logic                                 done_valid_i,
  input  logic [TID_WIDTH-1:0]                 done_tid_i,
  output logic [NB_CORES-1:0]                  term_event_o,
  output logic [NB_CORES-1:0]                  term_irq_o,
  output logic                                 busy_o
);

  localparam int CORE_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int NTID   = 2**TID_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NB_CORES][NUM_CFG_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NB_CORES][NUM_CFG_REGS];
  logic [DATA_WIDTH-1:0] rdata_q [NB_CORES];
  logic [DATA_WIDTH-1:0] rdata_d [NB_CORES];
  desc_t                 slot_q [NB_CORES];
  desc_t                 slot_d [NB_CORES];
  logic [NB_CORES-1:0]   slot_full_q, slot_full_d;
  logic [NB_CORES-1:0]   r_valid_q, r_valid_d;
  logic [CORE_W-1:0]     lrr_q, lrr_d, orr_q, orr_d, hold_sel_q, hold_sel_d;
  logic                  hold_q, hold_d;

  logic [NB_CORES-1:0]   launch_req;
  logic                  launch_found, launch_go, handshake;
  logic [CORE_W-1:0]     launch_idx, pick_idx, out_sel, lidx, oidx;
  logic [2:0]            off;
  logic [TID_WIDTH-1:0]  next_tid;
  logic                  next_free;
  logic [NTID-1:0]       bitmap;
  desc_t                 out_desc;
  logic                  unused_add;

  assign unused_add = ^ctrl_add_i;

  // Launch arbitration: first requesting core with an empty slot, starting at the RR pointer.
  always_comb begin
    launch_req   = '0;
    launch_found = 1'b0;
    launch_idx   = lrr_q;
    lidx         = '0;
    for (int c = 0; c < NB_CORES; c++)
      launch_req[c] = ctrl_req_i[c] && ctrl_wen_i[c] && (ctrl_add_i[c][4:2] == OFF_LAUNCH);
    for (int i = 0; i < NB_CORES; i++) begin
      lidx = CORE_W'((int'(lrr_q) + i) % NB_CORES);
      if (!launch_found && launch_req[lidx] && !slot_full_q[lidx]) begin
        launch_found = 1'b1;
        launch_idx   = lidx;
      end
    end
    launch_go = launch_found && next_free;
    for (int c = 0; c < NB_CORES; c++)
      ctrl_gnt_o[c] = ctrl_req_i[c] && (!launch_req[c] || (launch_go && launch_idx == CORE_W'(c)));
  end

  always_comb begin
    regs_d    = regs_q;
    rdata_d   = rdata_q;
    r_valid_d = ctrl_gnt_o;
    off       = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      off = ctrl_add_i[c][4:2];
      if (ctrl_req_i[c] && !ctrl_wen_i[c] && off <= OFF_CONF)
        for (int b = 0; b < BE_WIDTH; b++)
          if (ctrl_be_i[c][b]) regs_d[c][off][8*b +: 8] = ctrl_wdata_i[c][8*b +: 8];
      if (ctrl_gnt_o[c] && ctrl_wen_i[c]) begin
        case (off)
          OFF_LAUNCH: rdata_d[c] = DATA_WIDTH'(next_tid);
          OFF_STATUS: rdata_d[c] = DATA_WIDTH'(bitmap);
          default:    rdata_d[c] = regs_q[c][off];
        endcase
      end
    end
  end

  // Output arbiter; the selection is frozen while a descriptor is stalled by the backend.
  always_comb begin
    pick_idx     = orr_q;
    desc_valid_o = 1'b0;
    oidx         = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      oidx = CORE_W'((int'(orr_q) + i) % NB_CORES);
      if (!desc_valid_o && slot_full_q[oidx]) begin
        desc_valid_o = 1'b1;
        pick_idx     = oidx;
      end
    end
    out_sel    = hold_q ? hold_sel_q : pick_idx;
    out_desc   = slot_q[out_sel];
    handshake  = desc_valid_o && desc_ready_i;
    hold_d     = desc_valid_o && !desc_ready_i;
    hold_sel_d = out_sel;
    orr_d      = handshake ? CORE_W'(rr_next(int'(out_sel), NB_CORES)) : orr_q;
    lrr_d      = launch_go ? CORE_W'(rr_next(int'(launch_idx), NB_CORES)) : lrr_q;
  end

  always_comb begin
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    if (handshake) slot_full_d[out_sel] = 1'b0;
    if (launch_go) begin
      slot_full_d[launch_idx]     = 1'b1;
      slot_d[launch_idx].src      = {regs_q[launch_idx][OFF_SRC_HI], regs_q[launch_idx][OFF_SRC_LO]};
      slot_d[launch_idx].dst      = {regs_q[launch_idx][OFF_DST_HI], regs_q[launch_idx][OFF_DST_LO]};
      slot_d[launch_idx].len      = regs_q[launch_idx][OFF_LEN];
      slot_d[launch_idx].tid      = next_tid;
      slot_d[launch_idx].decouple = regs_q[launch_idx][OFF_CONF][CONF_DECOUPLE];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CORES; c++) begin
        for (int r = 0; r < NUM_CFG_REGS; r++) regs_q[c][r] <= '0;
        rdata_q[c] <= '0;
        slot_q[c]  <= '0;
      end
      slot_full_q <= '0;
      r_valid_q   <= '0;
      lrr_q       <= '0;
      orr_q       <= '0;
      hold_q      <= 1'b0;
      hold_sel_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      rdata_q     <= rdata_d;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      r_valid_q   <= r_valid_d;
      lrr_q       <= lrr_d;
      orr_q       <= orr_d;
      hold_q      <= hold_d;
      hold_sel_q  <= hold_sel_d;
    end
  end

  dmac_tid_alloc #(
    .NB_CORES  (NB_CORES),
    .TID_WIDTH (TID_WIDTH),
    .CORE_W    (CORE_W),
    .NTID      (NTID)
  ) u_tid_alloc (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .alloc_i          (launch_go),
    .alloc_core_i     (launch_idx),
    .alloc_irq_en_i   (regs_q[launch_idx][OFF_CONF][CONF_IRQ_EN]),
    .alloc_event_en_i (regs_q[launch_idx][OFF_CONF][CONF_EVENT_EN]),
    .next_tid_o       (next_tid),
    .next_free_o      (next_free),
    .retire_i         (done_valid_i),
    .retire_tid_i     (done_tid_i),
    .bitmap_o         (bitmap),
    .term_event_o     (term_event_o),
    .term_irq_o       (term_irq_o)
  );

  always_comb begin
    for (int c = 0; c < NB_CORES; c++) ctrl_r_rdata_o[c] = rdata_q[c];
  end

  assign ctrl_r_valid_o  = r_valid_q;
  assign desc_src_o      = out_desc.src;
  assign desc_dst_o      = out_desc.dst;
  assign desc_len_o      = out_desc.len;
  assign desc_tid_o      = out_desc.tid;
  assign desc_decouple_o = out_desc.decouple;
  assign busy_o          = (|bitmap) || (|slot_full_q);

endmodule

// File: tb/tb_dmac_desc_queue.sv
// Directed bench for dmac_desc_queue: register access, launch arbitration, TID exhaustion, completion, reset.
module tb_dmac_desc_queue;

  localparam int NC = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NC-1:0]         req = '0, wen = '0;
  logic [NC-1:0][31:0]   add = '0, wdata = '0;
  logic [NC-1:0][3:0]    be = '0;
  logic [NC-1:0]         gnt, rvalid;
  logic [NC-1:0][31:0]   rdata;
  logic                  desc_valid, desc_ready = 1'b0, dec;
  logic [63:0]           src, dst;
  logic [31:0]           len;
  logic [3:0]            tid;
  logic                  done_valid = 1'b0;
  logic [3:0]            done_tid = '0;
  logic [NC-1:0]         tev, tirq;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmac_desc_queue dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ctrl_req_i(req), .ctrl_wen_i(wen), .ctrl_add_i(add), .ctrl_wdata_i(wdata), .ctrl_be_i(be),
    .ctrl_gnt_o(gnt), .ctrl_r_valid_o(rvalid), .ctrl_r_rdata_o(rdata),
    .desc_valid_o(desc_valid), .desc_ready_i(desc_ready),
    .desc_src_o(src), .desc_dst_o(dst), .desc_len_o(len), .desc_tid_o(tid), .desc_decouple_o(dec),
    .done_valid_i(done_valid), .done_tid_i(done_tid),
    .term_event_o(tev), .term_irq_o(tirq), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One control access; retries up to budget cycles while gnt is low, returns rdata from the response.
  task automatic access(input int c, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int budget, output logic [31:0] rd, output logic g);
    logic gs;
    g  = 1'b0;
    rd = '0;
    @(negedge clk);
    req[c] = 1'b1; wen[c] = w; add[c] = a; wdata[c] = d; be[c] = b;
    for (int i = 0; i < budget && !g; i++) begin
      #1 gs = gnt[c];
      @(posedge clk);
      #1;
      if (gs) begin
        g  = 1'b1;
        rd = rdata[c];
        check("r_valid", {63'd0, rvalid[c]}, 64'd1);
      end
    end
    req[c] = 1'b0;
  endtask

  task automatic wr(input int c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] rd;
    logic g;
    access(c, 1'b0, a, d, b, 4, rd, g);
    check("wr_gnt", {63'd0, g}, 64'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; wen = '0; desc_ready = 1'b0; done_valid = 1'b0;
    #1;
    check("rst_desc_valid", {63'd0, desc_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_term", {56'd0, tev, tirq}, 64'd0);
    repeat (2) @(negedge clk);
    check("rst_r_valid", {60'd0, rvalid}, 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic g;

    apply_reset();

    // Single launch from core 0
    wr(0, 32'h00, 32'h1000_0100, 4'hF);
    wr(0, 32'h04, 32'h0, 4'hF);
    wr(0, 32'h08, 32'h8000_0000, 4'hF);
    wr(0, 32'h0C, 32'h0, 4'hF);
    wr(0, 32'h10, 32'h40, 4'hF);
    wr(0, 32'h14, 32'h6, 4'hF);
    access(0, 1'b1, 32'h18, 0, 0, 4, rd, g);
    check("launch_gnt", {63'd0, g}, 64'd1);
    check("launch_tid", {32'd0, rd}, 64'd0);
    check("desc_valid", {63'd0, desc_valid}, 64'd1);
    check("desc_src", src, 64'h1000_0100);
    check("desc_dst", dst, 64'h8000_0000);
    check("desc_len", {32'd0, len}, 64'h40);
    check("desc_tid", {60'd0, tid}, 64'd0);
    check("desc_dec", {63'd0, dec}, 64'd0);
    access(0, 1'b1, 32'h1C, 0, 0, 4, rd, g);
    check("status_1", {32'd0, rd}, 64'h1);
    @(negedge clk) desc_ready = 1'b1;
    @(posedge clk) #1 desc_ready = 1'b0;
    check("desc_drained", {63'd0, desc_valid}, 64'd0);
    check("busy_outstanding", {63'd0, busy}, 64'd1);

    // Four simultaneous launches
    apply_reset();
    wr(1, 32'h14, 32'h6, 4'hF);
    wr(0, 32'h00, 32'hC0C0_0000, 4'hF);
    @(posedge clk) #1;
    req = 4'hF; wen = 4'hF;
    for (int c = 0; c < NC; c++) add[c] = 32'h18;
    for (int cyc = 0; cyc < NC; cyc++) begin
      @(negedge clk);
      check("mlaunch_gnt", {60'd0, gnt}, 64'(1 << cyc));
      @(posedge clk) #1;
      check("mlaunch_tid", {32'd0, rdata[cyc]}, 64'(cyc));
      req[cyc] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, desc_valid}, 64'd1);
      check("stall_tid", {60'd0, tid}, 64'd0);
      check("stall_src", src, 64'hC0C0_0000);
    end
    desc_ready = 1'b1;
    for (int k = 0; k < NC; k++) begin
      check("drain_tid", {60'd0, tid}, 64'(k));
      @(negedge clk);
    end
    desc_ready = 1'b0;
    check("drain_empty", {63'd0, desc_valid}, 64'd0);

    // Completions: TID1 owned by core1 (CONF=6), TID2 owned by core2 (CONF=0)
    done_valid = 1'b1; done_tid = 4'd1;
    @(posedge clk) #1 done_valid = 1'b0;
    check("term_event", {60'd0, tev}, 64'b0010);
    check("term_irq", {60'd0, tirq}, 64'b0010);
    @(posedge clk) #1;
    check("term_one_cycle", {56'd0, tev, tirq}, 64'd0);
    @(negedge clk) done_valid = 1'b1; done_tid = 4'd1;
    @(posedge clk) #1 done_valid = 1'b0;
    check("term_repeat", {56'd0, tev, tirq}, 64'd0);
    @(negedge clk) done_valid = 1'b1; done_tid = 4'd2;
    @(posedge clk) #1 done_valid = 1'b0;
    check("term_disabled", {56'd0, tev, tirq}, 64'd0);
    access(3, 1'b1, 32'h1C, 0, 0, 4, rd, g);
    check("status_after_done", {32'd0, rd}, 64'h9);

    // Byte enables
    wr(0, 32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(0, 32'h10, 32'hAAAA_5555, 4'b0011);
    access(0, 1'b1, 32'h10, 0, 0, 4, rd, g);
    check("be_len", {32'd0, rd}, 64'hFFFF_5555);

    // TID exhaustion
    apply_reset();
    desc_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      access(0, 1'b1, 32'h18, 0, 0, 8, rd, g);
      check("exh_gnt", {63'd0, g}, 64'd1);
      check("exh_tid", {32'd0, rd}, 64'(t));
    end
    access(0, 1'b1, 32'h18, 0, 0, 3, rd, g);
    check("exh_stall", {63'd0, g}, 64'd0);
    @(negedge clk);
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h18;
    done_valid = 1'b1; done_tid = 4'd0;
    #1 check("exh_gnt_pre_clear", {63'd0, gnt[0]}, 64'd0);
    @(posedge clk) #1 done_valid = 1'b0;
    check("exh_no_term", {56'd0, tev, tirq}, 64'd0);
    #1 check("exh_gnt_after_done", {63'd0, gnt[0]}, 64'd1);
    @(posedge clk) #1;
    check("exh_rvalid", {63'd0, rvalid[0]}, 64'd1);
    check("exh_tid_reuse", {32'd0, rdata[0]}, 64'd0);
    req[0] = 1'b0;

    // Reset with 3 outstanding and 1 staged
    apply_reset();
    desc_ready = 1'b1;
    access(0, 1'b1, 32'h18, 0, 0, 4, rd, g);
    access(1, 1'b1, 32'h18, 0, 0, 4, rd, g);
    @(posedge clk) #1 desc_ready = 1'b0;
    access(2, 1'b1, 32'h18, 0, 0, 4, rd, g);
    check("pre_rst_tid", {32'd0, rd}, 64'd2);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    check("pre_rst_valid", {63'd0, desc_valid}, 64'd1);
    apply_reset();
    access(0, 1'b1, 32'h1C, 0, 0, 4, rd, g);
    check("post_rst_status", {32'd0, rd}, 64'd0);
    check("post_rst_valid", {63'd0, desc_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
